mem_stall_ctrl: RTL and testbench

- Sequences data-memory accesses for the MEM stage and owns the pipeline advance enable, pcEnable_o.
- pcEnable_o drives the PC, IF/ID, ID/EX and EX/MEM registers.
- A load or store held in EX/MEM freezes the whole pipe until memory acknowledges.
- Also inserts a one-cycle bubble for load-use hazards between ID/EX and IF/ID.

---
 rtl/mem_stall_ctrl_pkg.sv | 15 +
 rtl/mem_stall_ctrl_if.sv | 35 +++
 rtl/mem_stall_ctrl_hazard.sv | 20 ++
 rtl/mem_stall_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_stall_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stall_ctrl_pkg.sv
// Shared types and constants for the MEM-stage stall controller.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_IDX_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Data-memory request/acknowledge bus between the stall controller (master)
// and the memory (slave).
interface mem_stall_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/mem_stall_ctrl_hazard.sv
// Load-use hazard compare: a load in EX whose destination feeds a source of
// the instruction in ID. Register 0 never creates a hazard.
module hazard_detect
    import mem_ctrl_pkg::*;
(
    input  logic                 i_id_ex_memread,
    input  logic [REG_IDX_W-1:0] i_id_ex_rt,
    input  logic [REG_IDX_W-1:0] i_if_id_rs,
    input  logic [REG_IDX_W-1:0] i_if_id_rt,
    output logic                 o_lu
);

    // Pure combinational compare
    always_comb begin
        o_lu = i_id_ex_memread
             & (i_id_ex_rt != '0)
             & ((i_id_ex_rt == i_if_id_rs) | (i_id_ex_rt == i_if_id_rt));
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage data-memory sequencer and pipeline advance control.
// Optional: define MEM_TIMEOUT_EN to force completion of a WAIT that lasts
// TIMEOUT cycles, raising the sticky err_o flag.
module mem_stall_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 MemRead_i,
    input  logic                 MemWrite_i,
    input  logic [ADDR_W-1:0]    Address_i,
    input  logic [DATA_W-1:0]    Write_data_i,
    input  logic                 ID_EX_MemRead_i,
    input  logic [REG_IDX_W-1:0] ID_EX_Rt_i,
    input  logic [REG_IDX_W-1:0] IF_ID_Rs_i,
    input  logic [REG_IDX_W-1:0] IF_ID_Rt_i,
    mem_stall_ctrl_if.master     mem_bus,
    output logic [DATA_W-1:0]    rdata_o,
    output logic                 pcEnable_o,
    output logic                 IF_ID_write_o,
    output logic                 bubble_o,
    output logic                 err_o
);

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_op;
    logic              w_lu;
    logic              w_mem_stall;
    logic              w_in_access;
    logic              w_timeout;

    hazard_detect u_hazard (
        .i_id_ex_memread (ID_EX_MemRead_i),
        .i_id_ex_rt      (ID_EX_Rt_i),
        .i_if_id_rs      (IF_ID_Rs_i),
        .i_if_id_rt      (IF_ID_Rt_i),
        .o_lu            (w_lu)
    );

    assign w_op        = MemRead_i | MemWrite_i;
    assign w_in_access = (r_state == REQ) | (r_state == WAIT);
    assign w_mem_stall = w_in_access | ((r_state == IDLE) & w_op);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign w_timeout = (r_state == WAIT) & ~mem_bus.mem_ack_i
                     & (r_cnt == CNT_W'(TIMEOUT - 1));

    // Wait-cycle counter and sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_next == REQ) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT;
    assign err_o            = 1'b0;
`endif

    // Access sequencing: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_op) w_next = REQ;
            REQ:     w_next = mem_bus.mem_ack_i ? DONE : WAIT;
            WAIT:    if (mem_bus.mem_ack_i | w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register, request latches and load-data capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && w_op) begin
                r_addr  <= Address_i;
                r_wdata <= Write_data_i;
                r_we    <= MemWrite_i;
            end
            if (w_in_access && mem_bus.mem_ack_i && !r_we) begin
                r_rdata <= mem_bus.mem_rdata_i;
            end
        end
    end

    // Pipeline control: a memory stall freezes everything and suppresses the bubble
    always_comb begin
        pcEnable_o    = 1'b1;
        IF_ID_write_o = 1'b1;
        bubble_o      = 1'b0;
        if (w_mem_stall) begin
            pcEnable_o    = 1'b0;
            IF_ID_write_o = 1'b0;
        end else if (w_lu) begin
            pcEnable_o    = 1'b0;
            IF_ID_write_o = 1'b0;
            bubble_o      = 1'b1;
        end
    end

    assign mem_bus.mem_req_o   = (r_state == REQ);
    assign mem_bus.mem_we_o    = r_we;
    assign mem_bus.mem_addr_o  = r_addr;
    assign mem_bus.mem_wdata_o = r_wdata;
    assign rdata_o             = r_rdata;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed self-checking bench for mem_stall_ctrl.
// Timeout checks run only when MEM_TIMEOUT_EN is defined.
module tb_mem_stall_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Address_i;
    logic [31:0] Write_data_i;
    logic        ID_EX_MemRead_i;
    logic [4:0]  ID_EX_Rt_i;
    logic [4:0]  IF_ID_Rs_i;
    logic [4:0]  IF_ID_Rt_i;
    logic [31:0] rdata_o;
    logic        pcEnable_o;
    logic        IF_ID_write_o;
    logic        bubble_o;
    logic        err_o;

    int unsigned n_checks;
    int unsigned n_pass;

    mem_stall_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    mem_stall_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .MemRead_i       (MemRead_i),
        .MemWrite_i      (MemWrite_i),
        .Address_i       (Address_i),
        .Write_data_i    (Write_data_i),
        .ID_EX_MemRead_i (ID_EX_MemRead_i),
        .ID_EX_Rt_i      (ID_EX_Rt_i),
        .IF_ID_Rs_i      (IF_ID_Rs_i),
        .IF_ID_Rt_i      (IF_ID_Rt_i),
        .mem_bus         (mem_bus),
        .rdata_o         (rdata_o),
        .pcEnable_o      (pcEnable_o),
        .IF_ID_write_o   (IF_ID_write_o),
        .bubble_o        (bubble_o),
        .err_o           (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ctl(input string tag, input logic pc, input logic ifid, input logic bub);
        check({tag, ".pc"},     32'(pcEnable_o),    32'(pc));
        check({tag, ".ifid"},   32'(IF_ID_write_o), 32'(ifid));
        check({tag, ".bubble"}, 32'(bubble_o),      32'(bub));
    endtask

    task automatic req_is(input string tag, input logic exp);
        check({tag, ".req"}, 32'(mem_bus.mem_req_o), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_i = 1'b1;
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
        Address_i = '0; Write_data_i = '0;
        ID_EX_MemRead_i = 1'b0; ID_EX_Rt_i = '0; IF_ID_Rs_i = '0; IF_ID_Rt_i = '0;
        mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = '0;
        step(); step();
        rst_i = 1'b0;
        #1;

        // Reset state, plus a stray ack in IDLE that must be ignored
        ctl("rst", 1'b1, 1'b1, 1'b0);
        req_is("rst", 1'b0);
        check("rst.we",    32'(mem_bus.mem_we_o), 0);
        check("rst.addr",  mem_bus.mem_addr_o,    0);
        check("rst.wdata", mem_bus.mem_wdata_o,   0);
        check("rst.rdata", rdata_o,               0);
        check("rst.err",   32'(err_o),            0);
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h1111_2222;
        step();
        mem_bus.mem_ack_i = 1'b0;
        #1;
        check("idle_ack.rdata", rdata_o, 0);
        ctl("idle_ack", 1'b1, 1'b1, 1'b0);
        req_is("idle_ack", 1'b0);

        // Load from 0x40, ack three cycles after REQ
        MemRead_i = 1'b1; Address_i = 32'h40; Write_data_i = 32'h5555_5555;
        #1;
        ctl("ld.idle", 1'b0, 1'b0, 1'b0);
        req_is("ld.idle", 1'b0);
        step();
        ctl("ld.req", 1'b0, 1'b0, 1'b0);
        req_is("ld.req", 1'b1);
        check("ld.addr", mem_bus.mem_addr_o,    32'h40);
        check("ld.we",   32'(mem_bus.mem_we_o), 0);
        step();
        ctl("ld.w1", 1'b0, 1'b0, 1'b0);
        req_is("ld.w1", 1'b0);
        step();
        ctl("ld.w2", 1'b0, 1'b0, 1'b0);
        step();
        ctl("ld.w3", 1'b0, 1'b0, 1'b0);
        check("ld.w3.addr", mem_bus.mem_addr_o, 32'h40);
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'hDEAD_BEEF;
        step();
        mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = 32'h0;
        #1;
        ctl("ld.done", 1'b1, 1'b1, 1'b0);
        req_is("ld.done", 1'b0);
        check("ld.rdata", rdata_o, 32'hDEAD_BEEF);
        MemRead_i = 1'b0;
        step();
        ctl("ld.idle2", 1'b1, 1'b1, 1'b0);
        check("ld.hold", rdata_o, 32'hDEAD_BEEF);

        // Store 0x12345678 to 0x80, ack already high in REQ
        MemWrite_i = 1'b1; Address_i = 32'h80; Write_data_i = 32'h1234_5678;
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'hCAFE_F00D;
        #1;
        ctl("st.idle", 1'b0, 1'b0, 1'b0);
        step();
        req_is("st.req", 1'b1);
        ctl("st.req", 1'b0, 1'b0, 1'b0);
        check("st.we",    32'(mem_bus.mem_we_o), 1);
        check("st.addr",  mem_bus.mem_addr_o,    32'h80);
        check("st.wdata", mem_bus.mem_wdata_o,   32'h1234_5678);
        step();
        mem_bus.mem_ack_i = 1'b0;
        MemWrite_i = 1'b0;
        #1;
        ctl("st.done", 1'b1, 1'b1, 1'b0);
        check("st.rdata", rdata_o, 32'hDEAD_BEEF);
        step();
        ctl("st.idle2", 1'b1, 1'b1, 1'b0);

        // Back-to-back: load at 0x48, then read+write at 0x4C (write wins)
        MemRead_i = 1'b1; Address_i = 32'h48;
        step();
        req_is("bb1.req", 1'b1);
        check("bb1.addr", mem_bus.mem_addr_o, 32'h48);
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h0BAD_F00D;
        step();
        mem_bus.mem_ack_i = 1'b0;
        MemWrite_i = 1'b1; Address_i = 32'h4C; Write_data_i = 32'hA5A5_A5A5;
        #1;
        ctl("bb.done", 1'b1, 1'b1, 1'b0);
        check("bb1.rdata", rdata_o, 32'h0BAD_F00D);
        step();
        ctl("bb2.idle", 1'b0, 1'b0, 1'b0);
        req_is("bb2.idle", 1'b0);
        step();
        req_is("bb2.req", 1'b1);
        check("bb2.we",    32'(mem_bus.mem_we_o), 1);
        check("bb2.addr",  mem_bus.mem_addr_o,    32'h4C);
        check("bb2.wdata", mem_bus.mem_wdata_o,   32'hA5A5_A5A5);
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h7777_7777;
        step();
        mem_bus.mem_ack_i = 1'b0;
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
        #1;
        ctl("bb2.done", 1'b1, 1'b1, 1'b0);
        check("bb2.rdata", rdata_o, 32'h0BAD_F00D);
        step();

        // Load-use hazards with no memory op
        ID_EX_MemRead_i = 1'b1; ID_EX_Rt_i = 5'd5; IF_ID_Rs_i = 5'd5; IF_ID_Rt_i = 5'd9;
        #1;
        ctl("lu.rs", 1'b0, 1'b0, 1'b1);
        step();
        ID_EX_Rt_i = 5'd7; IF_ID_Rs_i = 5'd3; IF_ID_Rt_i = 5'd7;
        #1;
        ctl("lu.rt", 1'b0, 1'b0, 1'b1);
        ID_EX_Rt_i = 5'd0; IF_ID_Rs_i = 5'd0; IF_ID_Rt_i = 5'd0;
        #1;
        ctl("lu.r0", 1'b1, 1'b1, 1'b0);
        ID_EX_Rt_i = 5'd5; IF_ID_Rs_i = 5'd6; IF_ID_Rt_i = 5'd4;
        #1;
        ctl("lu.nomatch", 1'b1, 1'b1, 1'b0);
        ID_EX_MemRead_i = 1'b0; IF_ID_Rs_i = 5'd5;
        #1;
        ctl("lu.noload", 1'b1, 1'b1, 1'b0);
        step();

        // Load-use coincident with a memory stall, then reset during WAIT
        ID_EX_MemRead_i = 1'b1; ID_EX_Rt_i = 5'd5; IF_ID_Rs_i = 5'd5;
        MemRead_i = 1'b1; Address_i = 32'h90;
        #1;
        ctl("co.idle", 1'b0, 1'b0, 1'b0);
        step();
        ctl("co.req", 1'b0, 1'b0, 1'b0);
        step();
        ctl("co.w1", 1'b0, 1'b0, 1'b0);
`ifndef MEM_TIMEOUT_EN
        for (int i = 0; i < 20; i++) step();
        ctl("co.wlong", 1'b0, 1'b0, 1'b0);
        check("co.err", 32'(err_o), 0);
`endif
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        MemRead_i = 1'b0; ID_EX_MemRead_i = 1'b0;
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'hFEED_FACE;
        #1;
        ctl("rw.idle", 1'b1, 1'b1, 1'b0);
        req_is("rw.idle", 1'b0);
        check("rw.addr", mem_bus.mem_addr_o, 0);
        step();
        mem_bus.mem_ack_i = 1'b0;
        #1;
        check("rw.lateack.rdata", rdata_o, 0);
        ctl("rw.lateack", 1'b1, 1'b1, 1'b0);
        req_is("rw.lateack", 1'b0);

`ifdef MEM_TIMEOUT_EN
        // Never acknowledged: forced completion after 8 WAIT cycles
        MemRead_i = 1'b1; Address_i = 32'h10;
        step();
        req_is("to.req", 1'b1);
        step();
        ctl("to.w1", 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            step();
            ctl($sformatf("to.w%0d", i), 1'b0, 1'b0, 1'b0);
            check($sformatf("to.w%0d.err", i), 32'(err_o), 0);
        end
        step();
        MemRead_i = 1'b0;
        #1;
        ctl("to.done", 1'b1, 1'b1, 1'b0);
        check("to.err", 32'(err_o), 1);
        check("to.rdata", rdata_o, 0);
        step(); step();
        check("to.err_sticky", 32'(err_o), 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        check("to.err_rst", 32'(err_o), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
